// File: rtl/vec_pkg.sv
// vec_pkg: shared definitions for the vector operand pair buffer.
//   VEC_LANES / VEC_WIDTH : default lane count and lane width
//   lane_t, vec_t, pair_t : operand types at the default geometry
package vec_pkg;

  localparam int VEC_LANES = 4;
  localparam int VEC_WIDTH = 32;

  typedef logic [VEC_WIDTH-1:0] lane_t;
  typedef lane_t [VEC_LANES-1:0] vec_t;

  typedef struct packed {
    vec_t a;
    vec_t b;
  } pair_t;

endpackage

// File: rtl/vec_pair_fifo.sv
// vec_pair_fifo: DEPTH-entry FIFO of complete operand pairs.
// Ports:
//   clk, rst_n (sync, active-low), clr (sync clear of pointers/count)
//   push / din  : write din at the tail
//   pop         : advance the head
//   dout        : entry at the head (raw storage; caller gates with count)
//   count       : number of entries held
// The caller must never push when full without popping, nor pop when empty.
module vec_pair_fifo #(
  parameter  int DEPTH = 2,
  parameter  int DW    = 256,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] count
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is left untouched by reset/clear; the head is masked by count.
  always_ff @(posedge clk) begin
    if (rst_n && !clr && push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/vec_pair_buffer.sv
// vec_pair_buffer: collects operand vectors A then B into complete pairs,
// queues up to DEPTH pairs and presents the head pair over valid/ready.
// Ports:
//   clk, rst_n (sync, active-low), clr (sync clear of staged half + queue)
//   wr_valid/wr_ready/wr_data : operand write path, lane i at [i*WIDTH +: WIDTH]
//   wr_half                   : half the next accepted write fills (0=A, 1=B)
//   out_valid/out_ready       : head pair handshake
//   out_a/out_b               : head pair operands (zero when empty)
//   pair_count                : complete pairs queued
// Optional: define VEC_PAIR_LANE_MASK_EN to add wr_mask; lanes with a zero
// mask bit are stored as zero (both halves).
module vec_pair_buffer
  import vec_pkg::*;
#(
  parameter  int LANES = VEC_LANES,
  parameter  int WIDTH = VEC_WIDTH,
  parameter  int DEPTH = 2,
  localparam int VW    = LANES * WIDTH,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [VW-1:0]    wr_data,
  output logic             wr_half,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VW-1:0]    out_a,
  output logic [VW-1:0]    out_b,
  output logic [CW-1:0]    pair_count
`ifdef VEC_PAIR_LANE_MASK_EN
  ,
  input  logic [LANES-1:0] wr_mask
`endif
);

  logic          r_half;
  logic [VW-1:0] r_stage;
  logic [VW-1:0] w_wdata;
  logic [2*VW-1:0] w_head;
  logic [CW-1:0] w_count;
  logic          w_out_valid;
  logic          w_pop;
  logic          w_wr_ready;
  logic          w_accept;
  logic          w_push;

`ifdef VEC_PAIR_LANE_MASK_EN
  function automatic logic [VW-1:0] apply_mask(input logic [VW-1:0] d,
                                               input logic [LANES-1:0] m);
    logic [VW-1:0] res;
    res = '0;
    for (int i = 0; i < LANES; i++) begin
      if (m[i]) res[i*WIDTH +: WIDTH] = d[i*WIDTH +: WIDTH];
    end
    return res;
  endfunction

  assign w_wdata = apply_mask(wr_data, wr_mask);
`else
  assign w_wdata = wr_data;
`endif

  assign w_out_valid = (w_count != '0);
  assign w_pop       = w_out_valid && out_ready;
  // B can land in a full queue when the head leaves in the same cycle.
  assign w_wr_ready  = !r_half || (w_count < CW'(DEPTH)) || w_pop;
  assign w_accept    = wr_valid && w_wr_ready;
  assign w_push      = w_accept && r_half;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_half  <= 1'b0;
      r_stage <= '0;
    end else if (w_accept) begin
      if (!r_half) r_stage <= w_wdata;
      r_half <= !r_half;
    end
  end

  vec_pair_fifo #(
    .DEPTH (DEPTH),
    .DW    (2 * VW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (w_push),
    .pop   (w_pop),
    .din   ({r_stage, w_wdata}),
    .dout  (w_head),
    .count (w_count)
  );

  assign wr_ready   = w_wr_ready;
  assign wr_half    = r_half;
  assign out_valid  = w_out_valid;
  assign out_a      = w_out_valid ? w_head[2*VW-1:VW] : '0;
  assign out_b      = w_out_valid ? w_head[VW-1:0]    : '0;
  assign pair_count = w_count;

endmodule

// File: tb/tb_vec_pair_buffer.sv
module tb_vec_pair_buffer;

  localparam int LANES = 4;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int VW    = LANES * WIDTH;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct {
    logic [VW-1:0] a;
    logic [VW-1:0] b;
  } exp_pair_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [VW-1:0]    wr_data = '0;
  logic             wr_half;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [VW-1:0]    out_a;
  logic [VW-1:0]    out_b;
  logic [CW-1:0]    pair_count;
  logic [LANES-1:0] mask_tb = '1;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: a queue of expected pairs plus the half in progress.
  exp_pair_t     exp_q[$];
  logic          m_half = 1'b0;
  int            m_cnt  = 0;
  logic [VW-1:0] m_stage = '0;

  always #5 clk = ~clk;

  vec_pair_buffer #(
    .LANES (LANES),
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_half    (wr_half),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_a      (out_a),
    .out_b      (out_b),
    .pair_count (pair_count)
`ifdef VEC_PAIR_LANE_MASK_EN
    ,
    .wr_mask    (mask_tb)
`endif
  );

  task automatic chk(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] mkvec(input int l0, input int l1, input int l2, input int l3);
    logic [VW-1:0] v;
    v[0*WIDTH +: WIDTH] = l0;
    v[1*WIDTH +: WIDTH] = l1;
    v[2*WIDTH +: WIDTH] = l2;
    v[3*WIDTH +: WIDTH] = l3;
    return v;
  endfunction

  function automatic logic [VW-1:0] rndvec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [VW-1:0] masked(input logic [VW-1:0] d, input logic [LANES-1:0] m);
    logic [VW-1:0] r;
    r = '0;
`ifdef VEC_PAIR_LANE_MASK_EN
    for (int i = 0; i < LANES; i++) if (m[i]) r[i*WIDTH +: WIDTH] = d[i*WIDTH +: WIDTH];
`else
    r = d;
`endif
    return r;
  endfunction

  // Monitor: every pop is checked against the scoreboard head; an idle
  // output must read as zeros.
  always @(negedge clk) begin
    if (rst_n && !clr) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL pop_unexpected got out_valid=1 expected no pair queued");
        end else begin
          exp_pair_t e;
          e = exp_q.pop_front();
          chk("pop_a", out_a, e.a);
          chk("pop_b", out_b, e.b);
        end
      end else if (out_valid !== 1'b1) begin
        chk("idle_a", out_a, '0);
        chk("idle_b", out_b, '0);
      end
    end
  end

  // One clock: drive inputs, check control outputs against the model at the
  // falling edge, then advance the model across the rising edge.
  task automatic step(input logic rn, input logic c, input logic wv,
                      input logic [VW-1:0] d, input logic ordy);
    logic exp_rdy;
    logic do_pop;
    rst_n = rn; clr = c; wr_valid = wv; wr_data = d; out_ready = ordy;
    exp_rdy = !m_half || (m_cnt < DEPTH) || (ordy && m_cnt > 0);
    @(negedge clk);
    chk("wr_ready",   VW'(wr_ready),   VW'(exp_rdy));
    chk("wr_half",    VW'(wr_half),    VW'(m_half));
    chk("out_valid",  VW'(out_valid),  VW'(m_cnt > 0));
    chk("pair_count", VW'(pair_count), VW'(m_cnt));
    @(posedge clk);
    if (!rn || c) begin
      m_half = 1'b0; m_cnt = 0; m_stage = '0;
      exp_q.delete();
    end else begin
      do_pop = ordy && (m_cnt > 0);
      if (do_pop) m_cnt--;
      if (wv && exp_rdy) begin
        if (!m_half) begin
          m_stage = masked(d, mask_tb);
          m_half  = 1'b1;
        end else begin
          exp_pair_t e;
          e.a = m_stage;
          e.b = masked(d, mask_tb);
          exp_q.push_back(e);
          m_cnt++;
          m_half = 1'b0;
        end
      end
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state (still in reset), then single pair.
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b1, mkvec(15, 45, 74, 82), 1'b0);
    step(1'b1, 1'b0, 1'b1, mkvec(16, 46, 75, 83), 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("single_a", out_a, mkvec(15, 45, 74, 82));
    chk("single_b", out_b, mkvec(16, 46, 75, 83));
    @(posedge clk); #1;
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Fill to DEPTH, stall B, then pop-through.
    for (int k = 0; k < 2 * DEPTH; k++) step(1'b1, 1'b0, 1'b1, rndvec(), 1'b0);
    step(1'b1, 1'b0, 1'b1, rndvec(), 1'b0);
    step(1'b1, 1'b0, 1'b1, mkvec(1, 2, 3, 4), 1'b0);
    step(1'b1, 1'b0, 1'b1, mkvec(1, 2, 3, 4), 1'b0);
    step(1'b1, 1'b0, 1'b1, mkvec(5, 6, 7, 8), 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Ordered push/pop across pointer wrap.
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b0, 1'b1, mkvec(k, 0, 0, 0), 1'b0);
      step(1'b1, 1'b0, 1'b1, mkvec(k, 100, 0, 0), k[0]);
    end
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Clear mid-pair.
    step(1'b1, 1'b0, 1'b1, mkvec(7, 7, 7, 7), 1'b0);
    step(1'b1, 1'b1, 1'b1, rndvec(), 1'b1);
    step(1'b1, 1'b0, 1'b1, mkvec(9, 9, 9, 9), 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);

    // Reset priority over clr and a write while full.
    step(1'b1, 1'b0, 1'b1, rndvec(), 1'b0);
    for (int k = 0; k < 2 * DEPTH; k++) step(1'b1, 1'b0, 1'b1, rndvec(), 1'b0);
    step(1'b0, 1'b1, 1'b1, rndvec(), 1'b1);
    step(1'b1, 1'b0, 1'b1, rndvec(), 1'b0);
    step(1'b1, 1'b0, 1'b1, rndvec(), 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);

`ifdef VEC_PAIR_LANE_MASK_EN
    mask_tb = 4'b0101;
    step(1'b1, 1'b0, 1'b1, mkvec(15, 45, 74, 82), 1'b0);
    mask_tb = 4'b1111;
    step(1'b1, 1'b0, 1'b1, mkvec(16, 46, 75, 83), 1'b0);
    @(negedge clk);
    chk("mask_a", out_a, mkvec(15, 0, 74, 0));
    @(posedge clk); #1;
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
`endif

    // Randomized traffic with occasional clears.
    for (int k = 0; k < 400; k++) begin
`ifdef VEC_PAIR_LANE_MASK_EN
      mask_tb = 4'($urandom);
`endif
      step(1'b1, ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
           rndvec(), $urandom_range(0, 1) == 1);
    end
    for (int k = 0; k < DEPTH + 2; k++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
